power_pi_ctrl: RTL and testbench
================================

POWER_PI_CTRL -- requirements
Module: power_pi_ctrl

Interface
REQ-001 The block SHALL have parameters: KP 32'h3F800000 (proportional gain, IEEE-754 single); KI_TS 32'h3F000000 (Ki*Ts, single); OUT_MAX 32'h49742400 (upper clamp, 1.0e6); OUT_MIN 32'h00000000 (lower clamp); ADD_LAT 7 (float adder latency, cycles); MUL_LAT 5 (float multiplier latency, cycles).
REQ-002 The block SHALL have port clk_sim, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_control, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle pulse, driven from the MPPT done_finish_Pref output.
REQ-005 The block SHALL have port Pref, input, 32 bits: power reference from the MPPT stage (single).
REQ-006 The block SHALL have port Pmeas, input, 32 bits: measured electrical power (single).
REQ-007 The block SHALL have port Iref, output, 32 bits: clamped controller output (single).
REQ-008 The block SHALL have port done_Iref, output, 1 bit: one-cycle pulse marking Iref valid.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a computation is in flight.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag for a rejected start.

Function
REQ-011 An accepted start SHALL register Pref and Pmeas in the same cycle.
REQ-012 The FSM SHALL have the states IDLE, SUB, MUL, ADD_I, ADD_O, CLAMP and DONE, traversed in that order.
REQ-013 Each arithmetic state SHALL be held for its operator latency using a cycle counter: SUB=ADD_LAT, MUL=MUL_LAT, ADD_I=ADD_LAT, ADD_O=ADD_LAT; CLAMP SHALL last 1 cycle and DONE SHALL last 1 cycle.
REQ-014 SUB SHALL compute err = Pref - Pmeas.
REQ-015 MUL SHALL compute p = KP*err and k = KI_TS*err in parallel on two multipliers.
REQ-016 ADD_I SHALL compute integ_next = integ + k.
REQ-017 ADD_O SHALL compute u = p + integ_next.
REQ-018 CLAMP SHALL set Iref = OUT_MAX if u > OUT_MAX, Iref = OUT_MIN if u < OUT_MIN, and Iref = u otherwise.
REQ-019 Clamp comparisons SHALL be done in RTL on sign-magnitude-mapped bit patterns, with -0 equal to +0.
REQ-020 A NaN with sign bit 0 SHALL clamp to OUT_MAX, and a NaN with sign bit 1 SHALL clamp to OUT_MIN.
REQ-021 Iref and the integ register SHALL update only in CLAMP, so Iref holds its previous value throughout a computation.
REQ-022 done_Iref SHALL be high exactly in DONE, i.e. 2 + 3*ADD_LAT + MUL_LAT cycles after the accepted start cycle (28 at defaults).
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 start SHALL be accepted in IDLE or DONE; a start in DONE SHALL enter SUB on the next cycle, giving back-to-back operation with no gap.
REQ-025 A start in any other state SHALL be ignored, SHALL set overrun, and SHALL leave the computation undisturbed.
REQ-026 overrun SHALL clear only on reset.
REQ-027 Pref and Pmeas changes after capture SHALL NOT affect the computation in flight.

Reset
REQ-028 On rst_control high, outputs SHALL immediately be Iref=0, done_Iref=0, busy=0 and overrun=0.
REQ-029 On rst_control high, the integ register SHALL be 0, the FSM SHALL be IDLE and the counter SHALL be 0.
REQ-030 Reset mid-computation SHALL abort the computation with no done_Iref pulse.
REQ-031 The first start after reset release SHALL be accepted normally.
REQ-032 The float operator instances SHALL receive rst_control on their asynchronous clear inputs.

Configuration
REQ-033 With macro PI_ANTIWINDUP_EN defined, the integ register SHALL load integ_next clamped to [OUT_MIN, OUT_MAX] in CLAMP, using the REQ-019/REQ-020 comparator rules on a second comparator.
REQ-034 Without PI_ANTIWINDUP_EN, the integ register SHALL load integ_next unclamped, and the second comparator SHALL be absent.

Verification
REQ-035 Test 1: after reset (defaults), start with Pref=447A0000 (1000) and Pmeas=44160000 (600) -> done_Iref at cycle +28, Iref=44160000 (600), integ=43480000 (200).
REQ-036 Test 2: repeat the same inputs with start asserted during DONE of Test 1 -> second done_Iref 28 cycles later, Iref=44480000 (800).
REQ-037 Test 3: from reset, start with Pref=4A371B00 (3e6) and Pmeas=0 -> Iref=49742400 (OUT_MAX); integ=49742400 with PI_ANTIWINDUP_EN, 49B71B00 (1.5e6) without.
REQ-038 Test 4: from reset, start with Pref=0 and Pmeas=447A0000 -> u=-1500, Iref=00000000 (OUT_MIN).
REQ-039 Test 5: a start pulse at cycle +10 of a computation -> overrun=1, the in-flight result matches Test 1, and no extra done_Iref occurs.
REQ-040 Test 6: rst_control asserted at cycle +15 of a computation -> Iref=0, busy=0, no done_Iref; the next start then matches Test 1.

Source files
------------

// File: rtl/power_pi_ctrl.sv
// -----------------------------------------------------------------------------
// power_pi_ctrl
//
// Single-precision PI controller that turns a power reference from the MPPT
// stage into a clamped current reference.
//
//   err        = Pref - Pmeas
//   p          = KP * err
//   k          = KI_TS * err
//   integ_next = integ + k
//   u          = p + integ_next
//   Iref       = clamp(u, OUT_MIN, OUT_MAX)
//
// There is one shared float adder and two float multipliers. Each one is a
// combinational IEEE-754 core followed by LAT-1 pipeline registers. The
// controller's own capture register (err_q, pk_q, integ_next_q, u_q) adds the
// last register, so every operator shows its full latency. The FSM stays in
// each arithmetic state for exactly that latency.
//
// Float cores:
// - round to nearest even
// - subnormal inputs and results are flushed to signed zero
//
// Ports:
//   clk_sim      in   1  single clock
//   rst_control  in   1  asynchronous active-high reset
//   start        in   1  one-cycle request pulse (MPPT done_finish_Pref)
//   Pref         in  32  power reference (single)
//   Pmeas        in  32  measured power (single)
//   Iref         out 32  clamped controller output (single)
//   done_Iref    out  1  one-cycle pulse, Iref valid
//   busy         out  1  high whenever the FSM is not IDLE
//   overrun      out  1  sticky: start arrived while a computation was busy
//
// Build option:
//   PI_ANTIWINDUP_EN  clamp the integrator state to [OUT_MIN, OUT_MAX] as well
// -----------------------------------------------------------------------------
module power_pi_ctrl #(
  parameter logic [31:0] KP      = 32'h3F800000,
  parameter logic [31:0] KI_TS   = 32'h3F000000,
  parameter logic [31:0] OUT_MAX = 32'h49742400,
  parameter logic [31:0] OUT_MIN = 32'h00000000,
  parameter int          ADD_LAT = 7,
  parameter int          MUL_LAT = 5
) (
  input  logic        clk_sim,
  input  logic        rst_control,
  input  logic        start,
  input  logic [31:0] Pref,
  input  logic [31:0] Pmeas,
  output logic [31:0] Iref,
  output logic        done_Iref,
  output logic        busy,
  output logic        overrun
);

  localparam logic [31:0] QNAN  = 32'h7FC00000;
  localparam int          ADD_D = ADD_LAT - 1;
  localparam int          MUL_D = MUL_LAT - 1;

  typedef enum logic [2:0] {
    IDLE, SUB, MUL, ADD_I, ADD_O, CLAMP, DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Float helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] f_add(input logic [31:0] a_in,
                                        input logic [31:0] b_in);
    logic [31:0] a, b;
    logic [26:0] ma, mb;
    logic [27:0] sum;
    logic [24:0] mr;
    logic        up;
    int          d, er, lz;
    a = a_in;
    b = b_in;
    if (a[30:23] == 8'hFF && a[22:0] != '0) return QNAN;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return QNAN;
    if (a[30:23] == 8'hFF)
      return (b[30:23] == 8'hFF && a[31] != b[31]) ? QNAN : a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == '0 && b[30:23] == '0) return {a[31] & b[31], 31'h0};
    if (a[30:23] == '0) return b;
    if (b[30:23] == '0) return a;
    // Put the larger magnitude in a.
    if (b[30:0] > a[30:0]) begin
      a = b_in;
      b = a_in;
    end
    // Three extra low bits carry guard, round and sticky.
    ma = {1'b1, a[22:0], 3'b000};
    mb = {1'b1, b[22:0], 3'b000};
    d  = int'(a[30:23]) - int'(b[30:23]);
    er = int'(a[30:23]);
    if (d > 26) mb = 27'd1;
    else if (d > 0) mb = (mb >> d) | {26'd0, |(mb & ((27'd1 << d) - 27'd1))};
    if (a[31] == b[31]) begin
      sum = {1'b0, ma} + {1'b0, mb};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        er  = er + 1;
      end
    end else begin
      sum = {1'b0, ma} - {1'b0, mb};
      if (sum == '0) return 32'h0;
      lz = 0;
      for (int i = 0; i <= 26; i++) if (sum[i]) lz = 26 - i;
      sum = sum << lz;
      er  = er - lz;
      if (er <= 0) return {a[31], 31'h0};
    end
    up = sum[2] & (sum[1] | sum[0] | sum[3]);
    mr = {1'b0, sum[26:3]} + {24'd0, up};
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 1;
    end
    if (er >= 255) return {a[31], 8'hFF, 23'h0};
    return {a[31], 8'(er), mr[22:0]};
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] a,
                                        input logic [31:0] b);
    logic        s, g, st, up;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] prod;
    logic [23:0] m;
    logic [24:0] mr;
    int          er;
    s      = a[31] ^ b[31];
    a_nan  = a[30:23] == 8'hFF && a[22:0] != '0;
    b_nan  = b[30:23] == 8'hFF && b[22:0] != '0;
    a_inf  = a[30:23] == 8'hFF && a[22:0] == '0;
    b_inf  = b[30:23] == 8'hFF && b[22:0] == '0;
    a_zero = a[30:23] == '0;
    b_zero = b[30:23] == '0;
    if (a_nan || b_nan) return QNAN;
    if (a_inf || b_inf) return (a_zero || b_zero) ? QNAN : {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    er   = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m  = prod[47:24];
      g  = prod[23];
      st = |prod[22:0];
      er = er + 1;
    end else begin
      m  = prod[46:23];
      g  = prod[22];
      st = |prod[21:0];
    end
    up = g & (st | m[0]);
    mr = {1'b0, m} + {24'd0, up};
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 1;
    end
    if (er >= 255) return {s, 8'hFF, 23'h0};
    if (er <= 0) return {s, 31'h0};
    return {s, 8'(er), mr[22:0]};
  endfunction

  // Map sign-magnitude to an unsigned-ordered key. -0 is folded onto +0 first
  // so that the two zeros compare equal.
  function automatic logic [31:0] f_key(input logic [31:0] x);
    logic [31:0] z;
    z = (x[30:0] == '0) ? 32'h0 : x;
    return z[31] ? ~z : (z | 32'h80000000);
  endfunction

  function automatic logic [31:0] f_clamp(input logic [31:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != '0) return x[31] ? OUT_MIN : OUT_MAX;
    if (f_key(x) > f_key(OUT_MAX)) return OUT_MAX;
    if (f_key(x) < f_key(OUT_MIN)) return OUT_MIN;
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] pref_q, pref_d, pmeas_q, pmeas_d;
  logic [31:0] err_q, err_d;
  logic [63:0] pk_q, pk_d;            // {p, k}
  logic [31:0] integ_next_q, integ_next_d;
  logic [31:0] u_q, u_d;
  logic [31:0] integ_q, integ_d;
  logic [31:0] iref_q, iref_d;
  logic        overrun_q, overrun_d;

  logic [31:0] add_a, add_b, add_comb, add_res;
  logic [63:0] mul_comb, mul_res;

  // ---------------------------------------------------------------------------
  // Operators
  // ---------------------------------------------------------------------------
  // The adder is shared. Its operands are chosen by the current state, so each
  // state sees only its own operands across its whole latency window.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch.
    // Otherwise a path that skips the assignment infers a latch.
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      SUB:     begin add_a = pref_q;  add_b = {~pmeas_q[31], pmeas_q[30:0]}; end
      ADD_I:   begin add_a = integ_q; add_b = pk_q[31:0];                    end
      ADD_O:   begin add_a = pk_q[63:32]; add_b = integ_next_q;              end
      default: ;
    endcase
  end

  assign add_comb = f_add(add_a, add_b);
  assign mul_comb = {f_mul(KP, err_q), f_mul(KI_TS, err_q)};

  generate
    if (ADD_D == 0) begin : g_add_comb
      assign add_res = add_comb;
    end else begin : g_add_pipe
      logic [31:0] stage_q [ADD_D];
      // NOTE: the pipeline stages are reset like any other flop. rst_control
      // is defined to clear the operators, so a half-finished result cannot
      // survive an aborted computation.
      always_ff @(posedge clk_sim or posedge rst_control) begin
        if (rst_control) begin
          for (int i = 0; i < ADD_D; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= add_comb;
          for (int i = 1; i < ADD_D; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign add_res = stage_q[ADD_D-1];
    end

    if (MUL_D == 0) begin : g_mul_comb
      assign mul_res = mul_comb;
    end else begin : g_mul_pipe
      logic [63:0] stage_q [MUL_D];
      always_ff @(posedge clk_sim or posedge rst_control) begin
        if (rst_control) begin
          for (int i = 0; i < MUL_D; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= mul_comb;
          for (int i = 1; i < MUL_D; i++) stage_q[i] <= stage_q[i-1];
        end
      end
      assign mul_res = stage_q[MUL_D-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pref_d       = pref_q;
    pmeas_d      = pmeas_q;
    err_d        = err_q;
    pk_d         = pk_q;
    integ_next_d = integ_next_q;
    u_d          = u_q;
    integ_d      = integ_q;
    iref_d       = iref_q;
    overrun_d    = overrun_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          pref_d  = Pref;
          pmeas_d = Pmeas;
          state_d = SUB;
          cnt_d   = '0;
        end
      end
      SUB: begin
        if (cnt_q == 8'(ADD_LAT - 1)) begin
          err_d   = add_res;
          state_d = MUL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      MUL: begin
        if (cnt_q == 8'(MUL_LAT - 1)) begin
          pk_d    = mul_res;
          state_d = ADD_I;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      ADD_I: begin
        if (cnt_q == 8'(ADD_LAT - 1)) begin
          integ_next_d = add_res;
          state_d      = ADD_O;
          cnt_d        = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      ADD_O: begin
        if (cnt_q == 8'(ADD_LAT - 1)) begin
          u_d     = add_res;
          state_d = CLAMP;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      CLAMP: begin
        // Iref and the integrator are written only here, so Iref keeps its
        // previous value for the whole computation.
        iref_d  = f_clamp(u_q);
`ifdef PI_ANTIWINDUP_EN
        integ_d = f_clamp(integ_next_q);
`else
        integ_d = integ_next_q;
`endif
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A start that cannot be accepted is dropped. It only marks overrun.
    if (start && state_q != IDLE && state_q != DONE) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk_sim or posedge rst_control) begin
    if (rst_control) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pref_q       <= '0;
      pmeas_q      <= '0;
      err_q        <= '0;
      pk_q         <= '0;
      integ_next_q <= '0;
      u_q          <= '0;
      integ_q      <= '0;
      iref_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pref_q       <= pref_d;
      pmeas_q      <= pmeas_d;
      err_q        <= err_d;
      pk_q         <= pk_d;
      integ_next_q <= integ_next_d;
      u_q          <= u_d;
      integ_q      <= integ_d;
      iref_q       <= iref_d;
      overrun_q    <= overrun_d;
    end
  end

  assign Iref      = iref_q;
  assign done_Iref = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_power_pi_ctrl.sv
module tb_power_pi_ctrl;

  localparam logic [31:0] F1000 = 32'h447A0000;
  localparam logic [31:0] F600  = 32'h44160000;
  localparam logic [31:0] F200  = 32'h43480000;
  localparam logic [31:0] F800  = 32'h44480000;
  localparam logic [31:0] F3E6  = 32'h4A371B00;
  localparam logic [31:0] FMAX  = 32'h49742400;
  localparam logic [31:0] F15E6 = 32'h49B71B00;
  localparam logic [31:0] F2E5  = 32'h48435000;
  localparam logic [31:0] F7E5  = 32'h492AE600;
  localparam logic [31:0] FM500 = 32'hC3FA0000;
  localparam logic [31:0] F100  = 32'h42C80000;
  localparam int          LAT   = 28;

`ifdef PI_ANTIWINDUP_EN
  localparam logic [31:0] EXP_T3_INTEG  = FMAX;
  localparam logic [31:0] EXP_T3B_IREF  = F7E5;
  localparam logic [31:0] EXP_T4_INTEG  = 32'h0;
  localparam logic [31:0] EXP_T4B_IREF  = F600;
`else
  localparam logic [31:0] EXP_T3_INTEG  = F15E6;
  localparam logic [31:0] EXP_T3B_IREF  = FMAX;
  localparam logic [31:0] EXP_T4_INTEG  = FM500;
  localparam logic [31:0] EXP_T4B_IREF  = F100;
`endif

  logic        clk_sim = 1'b0;
  logic        rst_control;
  logic        start;
  logic [31:0] Pref, Pmeas;
  logic [31:0] Iref;
  logic        done_Iref, busy, overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sim = ~clk_sim;

  power_pi_ctrl dut (
    .clk_sim     (clk_sim),
    .rst_control (rst_control),
    .start       (start),
    .Pref        (Pref),
    .Pmeas       (Pmeas),
    .Iref        (Iref),
    .done_Iref   (done_Iref),
    .busy        (busy),
    .overrun     (overrun)
  );

  // The reset and stimulus tasks are called on a falling edge and return on one.
  task automatic do_reset();
    rst_control = 1'b1;
    start = 1'b0;
    Pref  = '0;
    Pmeas = '0;
    repeat (2) @(negedge clk_sim);
    rst_control = 1'b0;
    @(negedge clk_sim);
  endtask

  // Returns at the falling edge of cycle 1 (the cycle after acceptance). It
  // then puts garbage on the data inputs, which must not reach the result.
  task automatic pulse_start(input logic [31:0] pr, input logic [31:0] pm);
    start = 1'b1;
    Pref  = pr;
    Pmeas = pm;
    @(negedge clk_sim);
    start = 1'b0;
    Pref  = 32'hDEADBEEF;
    Pmeas = 32'h7F7FFFFF;
  endtask

  // Cycle index of the first done_Iref at or after cycle n0, or -1 on timeout.
  task automatic wait_done(input int n0, output int lat);
    lat = -1;
    for (int n = n0; n <= n0 + 60; n++) begin
      if (done_Iref) begin
        lat = n;
        break;
      end
      @(negedge clk_sim);
    end
  endtask

  task automatic test_reset();
    rst_control = 1'b1;
    start = 1'b0;
    Pref  = '0;
    Pmeas = '0;
    #1;
    n_cmp++; if (Iref !== 32'h0) begin n_bad++; $display("FAIL reset_iref: got %h expected %h", Iref, 32'h0); end
    n_cmp++; if (done_Iref !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done_Iref); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_cmp++; if (dut.integ_q !== 32'h0) begin n_bad++; $display("FAIL reset_integ: got %h expected 0", dut.integ_q); end
    repeat (2) @(negedge clk_sim);
    rst_control = 1'b0;
    @(negedge clk_sim);
  endtask

  task automatic test_basic();
    int lat;
    pulse_start(F1000, F600);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy: got %b expected 1", busy); end
    wait_done(1, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL t1_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (Iref !== F600) begin n_bad++; $display("FAIL t1_iref: got %h expected %h", Iref, F600); end
    n_cmp++; if (dut.integ_q !== F200) begin n_bad++; $display("FAIL t1_integ: got %h expected %h", dut.integ_q, F200); end
  endtask

  // Must be called in the DONE cycle of the previous computation.
  task automatic test_back_to_back();
    int lat;
    pulse_start(F1000, F600);
    repeat (9) @(negedge clk_sim);
    n_cmp++; if (Iref !== F600) begin n_bad++; $display("FAIL t2_iref_hold: got %h expected %h", Iref, F600); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t2_busy: got %b expected 1", busy); end
    wait_done(10, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL t2_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (Iref !== F800) begin n_bad++; $display("FAIL t2_iref: got %h expected %h", Iref, F800); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL t2_overrun: got %b expected 0", overrun); end
    @(negedge clk_sim);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_idle: got %b expected 0", busy); end
  endtask

  task automatic test_sat_high();
    int lat;
    do_reset();
    pulse_start(F3E6, 32'h0);
    wait_done(1, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL t3_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (Iref !== FMAX) begin n_bad++; $display("FAIL t3_iref: got %h expected %h", Iref, FMAX); end
    n_cmp++; if (dut.integ_q !== EXP_T3_INTEG) begin n_bad++; $display("FAIL t3_integ: got %h expected %h", dut.integ_q, EXP_T3_INTEG); end
    @(negedge clk_sim);
    pulse_start(32'h0, F2E5);
    wait_done(1, lat);
    n_cmp++; if (Iref !== EXP_T3B_IREF) begin n_bad++; $display("FAIL t3_followup_iref: got %h expected %h", Iref, EXP_T3B_IREF); end
  endtask

  task automatic test_sat_low();
    int lat;
    do_reset();
    pulse_start(32'h0, F1000);
    wait_done(1, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL t4_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (Iref !== 32'h0) begin n_bad++; $display("FAIL t4_iref: got %h expected %h", Iref, 32'h0); end
    n_cmp++; if (dut.integ_q !== EXP_T4_INTEG) begin n_bad++; $display("FAIL t4_integ: got %h expected %h", dut.integ_q, EXP_T4_INTEG); end
    @(negedge clk_sim);
    pulse_start(F1000, F600);
    wait_done(1, lat);
    n_cmp++; if (Iref !== EXP_T4B_IREF) begin n_bad++; $display("FAIL t4_followup_iref: got %h expected %h", Iref, EXP_T4B_IREF); end
  endtask

  task automatic test_overrun();
    int lat;
    int extra;
    do_reset();
    pulse_start(F1000, F600);
    repeat (9) @(negedge clk_sim);
    start = 1'b1;
    Pref  = F3E6;
    Pmeas = 32'h0;
    @(negedge clk_sim);
    start = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL t5_overrun: got %b expected 1", overrun); end
    wait_done(11, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL t5_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (Iref !== F600) begin n_bad++; $display("FAIL t5_iref: got %h expected %h", Iref, F600); end
    extra = 0;
    repeat (40) begin
      @(negedge clk_sim);
      if (done_Iref) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL t5_extra_done: got %0d expected 0", extra); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL t5_sticky: got %b expected 1", overrun); end
  endtask

  // Entered with Iref = 600 and overrun set, so the reset checks mean something.
  task automatic test_reset_mid();
    int lat;
    int seen;
    pulse_start(F1000, F600);
    repeat (14) @(negedge clk_sim);
    rst_control = 1'b1;
    #1;
    n_cmp++; if (Iref !== 32'h0) begin n_bad++; $display("FAIL t6_iref: got %h expected 0", Iref); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t6_busy: got %b expected 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL t6_overrun: got %b expected 0", overrun); end
    @(negedge clk_sim);
    rst_control = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk_sim);
      if (done_Iref) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL t6_no_done: got %0d expected 0", seen); end
    pulse_start(F1000, F600);
    wait_done(1, lat);
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL t6_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (Iref !== F600) begin n_bad++; $display("FAIL t6_iref_after: got %h expected %h", Iref, F600); end
    n_cmp++; if (dut.integ_q !== F200) begin n_bad++; $display("FAIL t6_integ_after: got %h expected %h", dut.integ_q, F200); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sat_high();
    test_sat_low();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
